pixel_write_unit: RTL and testbench

//  Downstream of the rectangle/line draw stage. Accepts its stream of (X,Y) points
//  and buffers them in a small FIFO. Clips points outside the screen. Converts

---
 rtl/pixel_write_unit.sv | 162 ++++++++++++++++
 tb/tb_pixel_write_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_unit.sv
// pixel_write_unit
//   Takes (X,Y,COLOR) points from the draw stage and drops any that fall off
//   screen. On-screen points go into an 8-entry FIFO. A two-state writer drains
//   the FIFO into video RAM using a WE/READY handshake. DONE pulses once a finish
//   has been seen and all buffered pixels have been written.
//
// Ports
//   ACLK, ARESET        clock (rising edge), async active-high reset
//   PT_VALID            X_In/Y_In/COLOR carry a point this cycle
//   X_In, Y_In, COLOR   point column/row and pixel value
//   PT_FINISH           drawer finished (rising edge is used)
//   FULL                registered FIFO-full; upstream must hold off
//   MEM_ADDR, MEM_DATA  write address (Y*H_RES+X) and data
//   MEM_WE, MEM_READY   write request / accept
//   DONE                one-cycle completion pulse
//   OVERFLOW            sticky: an on-screen point was dropped because FULL
//   CLIP_CNT            saturating count of off-screen points
//   state_dbg           writer state (0 = IDLE, 1 = WRITE)
//
// Handshake: MEM_WE is asserted with stable MEM_ADDR/MEM_DATA. The write
// completes on the rising edge where MEM_WE and MEM_READY are both high. The
// next point, if any, is presented on the very next cycle.
module pixel_write_unit #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8,
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int ADDR_W  = 15,
  parameter int FIFO_AW = 3
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               PT_VALID,
  input  logic [COORD_W-1:0] X_In,
  input  logic [COORD_W-1:0] Y_In,
  input  logic [COLOR_W-1:0] COLOR,
  input  logic               PT_FINISH,
  output logic               FULL,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [COLOR_W-1:0] MEM_DATA,
  output logic               MEM_WE,
  input  logic               MEM_READY,
  output logic               DONE,
  output logic               OVERFLOW,
  output logic [7:0]         CLIP_CNT,
  output logic               state_dbg
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  state_t state;

  logic [COORD_W-1:0] x_mem [DEPTH];
  logic [COORD_W-1:0] y_mem [DEPTH];
  logic [COLOR_W-1:0] c_mem [DEPTH];

  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_next;
  logic               empty, in_range, pop, push, fin_d, fin_rise, pending, done_fire;
  logic [ADDR_W-1:0]  head_addr;

  assign empty    = (count == '0);
  assign in_range = (int'(X_In) < H_RES) && (int'(Y_In) < V_RES);

  // The writer takes the head whenever it is idle or its current write is completing.
  assign pop  = !empty && ((state == IDLE) || MEM_READY);
  // A push that coincides with a pop always fits, even when FULL.
  assign push = PT_VALID && in_range && (!FULL || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  assign head_addr = ADDR_W'(y_mem[rd_ptr]) * ADDR_W'(H_RES) + ADDR_W'(x_mem[rd_ptr]);

  assign fin_rise  = PT_FINISH && !fin_d;
  assign done_fire = pending && (state == IDLE) && empty;
  assign state_dbg = (state == WRITE);

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      x_mem[wr_ptr] <= X_In;
      y_mem[wr_ptr] <= Y_In;
      c_mem[wr_ptr] <= COLOR;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      FULL   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      FULL  <= (count_next == (FIFO_AW+1)'(DEPTH));
    end
  end

  // Writer FSM with registered outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            MEM_ADDR <= head_addr;
            MEM_DATA <= c_mem[rd_ptr];
            MEM_WE   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (MEM_READY) begin
            if (!empty) begin
              MEM_ADDR <= head_addr;
              MEM_DATA <= c_mem[rd_ptr];
              MEM_WE   <= 1'b1;
            end else begin
              MEM_WE <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          MEM_WE <= 1'b0;
        end
      endcase
    end
  end

  // Finish tracking and status flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fin_d    <= 1'b0;
      pending  <= 1'b0;
      DONE     <= 1'b0;
      OVERFLOW <= 1'b0;
      CLIP_CNT <= '0;
    end else begin
      fin_d <= PT_FINISH;
      DONE  <= done_fire;
      // done_fire implies pending, so a finish arriving while pending is merged.
      if (done_fire)     pending <= 1'b0;
      else if (fin_rise) pending <= 1'b1;
      if (PT_VALID && in_range && FULL && !pop) OVERFLOW <= 1'b1;
      if (PT_VALID && !in_range && (CLIP_CNT != 8'hFF)) CLIP_CNT <= CLIP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_write_unit.sv
module tb_pixel_write_unit;

  logic        ACLK = 1'b0;
  logic        ARESET, PT_VALID, PT_FINISH, MEM_READY;
  logic [7:0]  X_In, Y_In, COLOR;
  logic        FULL, MEM_WE, DONE, OVERFLOW, state_dbg;
  logic [14:0] MEM_ADDR;
  logic [7:0]  MEM_DATA, CLIP_CNT;

  pixel_write_unit dut (
    .ACLK(ACLK), .ARESET(ARESET), .PT_VALID(PT_VALID), .X_In(X_In), .Y_In(Y_In),
    .COLOR(COLOR), .PT_FINISH(PT_FINISH), .FULL(FULL), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE), .MEM_READY(MEM_READY), .DONE(DONE),
    .OVERFLOW(OVERFLOW), .CLIP_CNT(CLIP_CNT), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int ncyc = 0, wr_cnt = 0, last_wr = 0, done_cnt = 0, done_at = 0;
  logic [22:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] addr_of(input int x, input int y);
    return 15'(y * 160 + x);
  endfunction

  // scoreboard: a write completes on the edge following a negedge with WE & READY
  always @(negedge ACLK) begin
    logic [22:0] e;
    ncyc++;
    if (!ARESET && MEM_WE && MEM_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(MEM_ADDR), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(MEM_ADDR), 32'(e[22:8]));
        check("write_data", 32'(MEM_DATA), 32'(e[7:0]));
      end
      wr_cnt++;
      last_wr = ncyc;
    end
    if (!ARESET && DONE) begin
      done_cnt++;
      done_at = ncyc;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [7:0] c, input bit store);
    PT_VALID = 1'b1;
    X_In = 8'(x);
    Y_In = 8'(y);
    COLOR = c;
    if (store) exp_q.push_back({addr_of(x, y), c});
    step();
    PT_VALID = 1'b0;
  endtask

  task automatic finish_pulse();
    PT_FINISH = 1'b1;
    step();
    PT_FINISH = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      #1;
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    step();
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  color;
    bit          fin;
    logic [14:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit got;
    int d0, w0;
    logic [14:0] snap_addr;
    logic [7:0]  snap_data;
    logic [7:0]  c;

    vecs[0] = '{0, 0, 8'h11, 1'b0, 15'd0};
    vecs[1] = '{1, 1, 8'h22, 1'b0, 15'd161};
    vecs[2] = '{2, 2, 8'h33, 1'b0, 15'd322};
    vecs[3] = '{3, 3, 8'h44, 1'b0, 15'd483};
    vecs[4] = '{4, 4, 8'h55, 1'b0, 15'd644};
    vecs[5] = '{5, 5, 8'h66, 1'b1, 15'd805};

    ARESET = 1'b1; PT_VALID = 1'b0; PT_FINISH = 1'b0; MEM_READY = 1'b1;
    X_In = '0; Y_In = '0; COLOR = '0;
    repeat (3) step();
    ARESET = 1'b0;
    check("rst_we", 32'(MEM_WE), 0);
    check("rst_addr", 32'(MEM_ADDR), 0);
    check("rst_data", 32'(MEM_DATA), 0);
    check("rst_full", 32'(FULL), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_clip", 32'(CLIP_CNT), 0);
    check("rst_state", 32'(state_dbg), 0);

    // diagonal, back-to-back, finish with the last point
    for (int i = 0; i < 6; i++) begin
      PT_FINISH = vecs[i].fin;
      exp_q.push_back({vecs[i].exp_addr, vecs[i].color});
      PT_VALID = 1'b1; X_In = 8'(vecs[i].x); Y_In = 8'(vecs[i].y); COLOR = vecs[i].color;
      step();
      PT_VALID = 1'b0; PT_FINISH = 1'b0;
      if (i == 0) check("first_we_latency0", 32'(MEM_WE), 0);
      if (i == 1) begin
        check("first_we_latency1", 32'(MEM_WE), 1);
        check("first_addr", 32'(MEM_ADDR), 0);
      end
      if (i >= 2) check("b2b_we", 32'(MEM_WE), 1);
    end
    wait_done(30, got);
    check("diag_done_seen", 32'(got), 1);
    check("diag_done_timing", 32'(done_at - last_wr), 2);
    check("diag_done_cnt", 32'(done_cnt), 1);
    check("diag_q_empty", 32'(exp_q.size()), 0);
    step();
    check("diag_done_pulse", 32'(DONE), 0);

    // clipped points
    push(160, 0, 8'hA1, 1'b0);
    check("clip_1", 32'(CLIP_CNT), 1);
    push(0, 120, 8'hA2, 1'b0);
    check("clip_2", 32'(CLIP_CNT), 2);
    push(255, 255, 8'hA3, 1'b0);
    check("clip_3", 32'(CLIP_CNT), 3);
    check("clip_no_we", 32'(MEM_WE), 0);
    d0 = done_cnt;
    finish_pulse();
    wait_done(10, got);
    check("clip_done_seen", 32'(got), 1);
    check("clip_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // finish on empty, then a held finish
    d0 = done_cnt;
    finish_pulse();
    wait_done(10, got);
    check("empty_done_seen", 32'(got), 1);
    repeat (3) step();
    check("empty_done_once", 32'(done_cnt), 32'(d0 + 1));
    PT_FINISH = 1'b1;
    repeat (5) step();
    PT_FINISH = 1'b0;
    repeat (5) step();
    check("held_finish_single_done", 32'(done_cnt), 32'(d0 + 2));

    // stall the first write and fill the FIFO
    MEM_READY = 1'b0;
    snap_addr = '0; snap_data = '0;
    for (int k = 1; k <= 10; k++) begin
      c = 8'($urandom_range(0, 255));
      push(10 + k, 20 + k, c, k <= 9);
      if (k == 2) begin
        check("stall_we", 32'(MEM_WE), 1);
        check("stall_addr0", 32'(MEM_ADDR), 32'(addr_of(11, 21)));
        snap_addr = MEM_ADDR;
        snap_data = MEM_DATA;
      end
      if (k > 2) begin
        check("stall_we_hold", 32'(MEM_WE), 1);
        check("stall_addr_hold", 32'(MEM_ADDR), 32'(snap_addr));
        check("stall_data_hold", 32'(MEM_DATA), 32'(snap_data));
      end
      check("fill_full", 32'(FULL), 32'(k >= 9));
      check("fill_ovf", 32'(OVERFLOW), 32'(k == 10));
    end
    MEM_READY = 1'b1;
    drain(40);
    check("ovf_sticky", 32'(OVERFLOW), 1);

    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("ovf_cleared", 32'(OVERFLOW), 0);
    check("clip_cleared", 32'(CLIP_CNT), 0);

    // corner pixel, then push+pop while FULL
    push(159, 119, 8'h5A, 1'b1);
    drain(10);
    MEM_READY = 1'b0;
    for (int k = 0; k < 9; k++) push(k * 7, k * 3, 8'($urandom_range(0, 255)), 1'b1);
    check("pp_full_before", 32'(FULL), 1);
    MEM_READY = 1'b1;
    push(100, 100, 8'hC3, 1'b1);
    check("pp_full_after", 32'(FULL), 1);
    check("pp_no_ovf", 32'(OVERFLOW), 0);
    drain(40);
    check("pp_no_ovf_end", 32'(OVERFLOW), 0);

    // reset in the middle of a write
    MEM_READY = 1'b0;
    for (int k = 0; k < 4; k++) push(50 + k, 60, 8'(k), 1'b1);
    step();
    check("mid_we_before", 32'(MEM_WE), 1);
    ARESET = 1'b1;
    #1;
    check("mid_we_dropped", 32'(MEM_WE), 0);
    check("mid_full", 32'(FULL), 0);
    exp_q.delete();
    step();
    ARESET = 1'b0;
    MEM_READY = 1'b1;
    w0 = wr_cnt;
    repeat (10) step();
    check("mid_no_writes", 32'(wr_cnt), 32'(w0));
    push(7, 9, 8'h77, 1'b1);
    drain(10);
    check("mid_new_write", 32'(wr_cnt), 32'(w0 + 1));

    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
